axi_write_queue: RTL and testbench
==================================

# axi_write_queue

Buffered request source for the low-priority (FSM) port of the AXI-Lite write stage. Producers push 32-bit address/data write entries into a small synchronous FIFO. The block then presents them one at a time on a level req / one-cycle ack handshake, so bursts of writes never stall their source. It sits directly upstream of the AXI-Lite write stage: `wr_*` connect to that stage's `fsm_*` inputs/outputs.

## Interface
Parameters:
- `DEPTH`, 8, number of FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 1024, ack watchdog limit; only used with `AXI_WQ_TIMEOUT_EN`.

Ports:
- `seq_port`, `ADAM_SEQ.Slave`, clock `seq_port.clk` and reset `seq_port.rst`. One clock; reset is synchronous and active-high.
- `push_valid_i`, in, 1, producer has an entry.
- `push_ready_o`, in/out, 1 (out), entry is accepted when `push_valid_i && push_ready_o` at the clock edge.
- `push_addr_i`, in, 32, write address.
- `push_data_i`, in, 32, write data.
- `flush_i`, in, 1, discard all queued entries that are not in flight.
- `wr_adress_o`, out, 32, address of the head entry.
- `wr_data_o`, out, 32, data of the head entry.
- `wr_req_o`, out, 1, head entry is requesting a write.
- `wr_ack_i`, in, 1, single-cycle acknowledge from the write stage.
- `level_o`, out, $clog2(DEPTH+1), entries held, including the one in flight.
- `empty_o`, out, 1, level is 0.
- `full_o`, out, 1, level equals `DEPTH`.
- `idle_o`, out, 1, queue empty and FSM in IDLE.
- `timeout_o`, out, 1, sticky watchdog flag (see Configuration).

## Operation
- Reset values: `wr_req_o`=0, `wr_adress_o`=0, `wr_data_o`=0, `push_ready_o`=1, `level_o`=0, `empty_o`=1, `full_o`=0, `idle_o`=1, `timeout_o`=0. FIFO pointers are cleared.
- `push_ready_o` = !`full_o`. A push is refused when full, even if a pop happens in the same cycle.
- The head entry stays in the FIFO until it is acked, and it counts in `level_o`.
- FSM states:
  - IDLE → ISSUE when level > 0.
  - ISSUE: `wr_req_o`=1. On `wr_ack_i`: pop the head; stay in ISSUE if entries remain after the pop (counting a same-cycle push), else go to IDLE.
- `wr_ack_i` is ignored in IDLE.
- `wr_adress_o` and `wr_data_o` are registered copies of the head entry. They are constant while `wr_req_o`=1 and change only on the cycle after a pop.
- `flush_i`:
  - In IDLE it empties the FIFO.
  - In ISSUE it keeps only the head (level→1). The in-flight write still completes.
  - A push in the same cycle as a flush is discarded; `push_ready_o` is still honoured.
- Push and ack in the same cycle: both take effect, so level is unchanged.
- Pointers wrap modulo `DEPTH`. `level_o` uses one extra bit so it can distinguish full from empty.
- Reset in mid-operation drops `wr_req_o` in the next cycle and loses all entries. The write stage shares the same reset.

## Timing
- Push into an empty queue at edge N: `wr_req_o`=1 and the entry is on `wr_*` in cycle N+1.
- Ack sampled at edge M: the next entry is on `wr_*` in cycle M+1, with `wr_req_o` held high. If the queue is empty, `wr_req_o`=0 in cycle M+1.
- The write stage does not resample `wr_req_o` in the ack cycle, so back-to-back entries need no request gap.
- `level_o`, `empty_o` and `full_o` are registered and update one cycle after the push/pop edge.

## Configuration
- `AXI_WQ_TIMEOUT_EN` defined:
  - A cycle counter runs while in ISSUE and clears on ack.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_o` is set. It stays set until reset.
  - The queue does not drop or retry the request.
- `AXI_WQ_TIMEOUT_EN` undefined: no counter is built and `timeout_o` is tied to 0.

## Structure
- Package `axi_wq_pkg`:
  - `wr_entry_t` struct: {addr[31:0], data[31:0]}.
  - `wq_state_t` enum: {IDLE, ISSUE}.
  - Default constants for `DEPTH` and `TIMEOUT_CYCLES`.
- Sub-module `wq_fifo`: synchronous FIFO of `wr_entry_t` with push/pop/flush_keep_head, head output and level output. The top level holds the FSM, the output registers and the watchdog.

## Test plan
- Single write: push (0x100, 0xDEAD) → `wr_req_o`=1 next cycle with those values. Ack 3 cycles later → `wr_req_o`=0 and `idle_o`=1.
- Burst: push 8 entries back-to-back with `DEPTH`=8 → `full_o`=1 and `push_ready_o`=0. Each ack advances to the next entry with no req gap. Entries drain in push order.
- Simultaneous push and ack at level 3 → level stays 3 and the head advances.
- Flush in ISSUE with level 5 → level becomes 1 and the in-flight entry is held until ack. The following cycle is IDLE with `empty_o`=1.
- Reset asserted while in ISSUE with level 4 → next cycle `wr_req_o`=0, `level_o`=0 and all outputs are at reset values.
- With `AXI_WQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, withhold ack → `timeout_o`=1 after 16 cycles in ISSUE and stays set after a later ack.

Source files
------------

// File: rtl/axi_wq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_wq_pkg : shared types and defaults for the AXI-Lite write queue       |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package axi_wq_pkg;

  localparam int c_depth_default   = 8;
  localparam int c_timeout_default = 1024;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wq_state_t;

endpackage
`default_nettype wire

// File: rtl/ADAM_SEQ.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ADAM_SEQ : clock / synchronous active-high reset bundle                   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport Master (output clk, output rst);
  modport Slave  (input clk, input rst);
endinterface
`default_nettype wire

// File: rtl/wq_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wq_fifo  : synchronous FIFO of write entries with keep-head flush and a   |
// |            look-ahead view of the next head entry                         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module wq_fifo
  import axi_wq_pkg::*;
#(
  parameter int DEPTH = c_depth_default
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wr_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         flush_all,
  input  logic                         flush_keep_head,
  output wr_entry_t                    head_nxt,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   level_nxt
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = $clog2(DEPTH+1);

  wr_entry_t         r_mem [DEPTH];
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_lw-1:0]   r_level;
  logic [c_aw-1:0]   w_rd_ptr_nxt;
  logic [c_aw-1:0]   w_wr_ptr_nxt;
  logic [c_lw-1:0]   w_rem;
  logic              w_write;

  assign w_write = push && !flush_all && !flush_keep_head;
  assign level   = r_level;

  always_comb begin
    w_rem        = r_level - c_lw'(pop);
    w_rd_ptr_nxt = r_rd_ptr + c_aw'(pop);
    // With nothing left after the pop, the next head is the entry arriving now.
    head_nxt     = (w_rem == '0) ? push_entry : r_mem[w_rd_ptr_nxt];
    w_wr_ptr_nxt = r_wr_ptr;
    level_nxt    = r_level;
    if (flush_all) begin
      w_wr_ptr_nxt = w_rd_ptr_nxt;
      level_nxt    = '0;
    end else if (flush_keep_head) begin
      if (pop || (r_level == '0)) begin
        w_wr_ptr_nxt = w_rd_ptr_nxt;
        level_nxt    = '0;
      end else begin
        w_wr_ptr_nxt = r_rd_ptr + c_aw'(1);
        level_nxt    = c_lw'(1);
      end
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + c_aw'(w_write);
      level_nxt    = w_rem + c_lw'(w_write);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_level  <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_write_queue : buffered req/ack write source for the AXI-Lite write    |
// |                   stage FSM port. Optional ack watchdog: AXI_WQ_TIMEOUT_EN |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module axi_write_queue
  import axi_wq_pkg::*;
#(
  parameter int DEPTH          = c_depth_default,
  parameter int TIMEOUT_CYCLES = c_timeout_default
) (
  ADAM_SEQ.Slave                       seq_port,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [31:0]                  push_addr_i,
  input  logic [31:0]                  push_data_i,
  input  logic                         flush_i,
  output logic [31:0]                  wr_adress_o,
  output logic [31:0]                  wr_data_o,
  output logic                         wr_req_o,
  input  logic                         wr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         idle_o,
  output logic                         timeout_o
);

  localparam int c_lw = $clog2(DEPTH+1);

  logic              w_clk;
  logic              w_rst;
  wq_state_t         r_state;
  wq_state_t         w_state_nxt;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  wr_entry_t         w_push_entry;
  wr_entry_t         w_head_nxt;
  logic [c_lw-1:0]   w_level;
  logic [c_lw-1:0]   w_level_nxt;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;

  assign w_clk = seq_port.clk;
  assign w_rst = seq_port.rst;

  assign empty_o      = (w_level == '0);
  assign full_o       = (w_level == c_lw'(DEPTH));
  assign push_ready_o = !full_o;
  assign level_o      = w_level;
  assign wr_req_o     = (r_state == ISSUE);
  assign idle_o       = empty_o && (r_state == IDLE);
  assign wr_adress_o  = r_addr;
  assign wr_data_o    = r_data;

  // A flush always wins over a same-cycle push; readiness is unaffected.
  assign w_push       = push_valid_i && push_ready_o && !flush_i;
  assign w_pop        = (r_state == ISSUE) && wr_ack_i;
  assign w_push_entry = '{addr: push_addr_i, data: push_data_i};

  wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk             (w_clk),
    .rst             (w_rst),
    .push            (w_push),
    .push_entry      (w_push_entry),
    .pop             (w_pop),
    .flush_all       (flush_i && (r_state == IDLE)),
    .flush_keep_head (flush_i && (r_state == ISSUE)),
    .head_nxt        (w_head_nxt),
    .level           (w_level),
    .level_nxt       (w_level_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level_nxt != '0) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end
      end
      ISSUE: begin
        if (w_pop) begin
          if (w_level_nxt != '0) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_addr <= w_head_nxt.addr;
        r_data <= w_head_nxt.data;
      end
    end
  end

`ifdef AXI_WQ_TIMEOUT_EN
  localparam int c_cw = $clog2(TIMEOUT_CYCLES+1);

  logic [c_cw-1:0] r_wd_cnt;
  logic            r_timeout;

  // Counts consecutive un-acked ISSUE cycles; the flag is sticky until reset.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state != ISSUE) || wr_ack_i) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != c_cw'(TIMEOUT_CYCLES)) begin
        r_wd_cnt <= r_wd_cnt + c_cw'(1);
      end
      if ((r_state == ISSUE) && !wr_ack_i && (r_wd_cnt == c_cw'(TIMEOUT_CYCLES-1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_write_queue : directed self-checking bench for axi_write_queue     |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_axi_write_queue;

  ADAM_SEQ seq_if ();

  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_data;
  logic        flush;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_req;
  logic        wr_ack;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        idle;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  axi_write_queue #(
    .DEPTH          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .seq_port     (seq_if),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_addr_i  (push_addr),
    .push_data_i  (push_data),
    .flush_i      (flush),
    .wr_adress_o  (wr_addr),
    .wr_data_o    (wr_data),
    .wr_req_o     (wr_req),
    .wr_ack_i     (wr_ack),
    .level_o      (level),
    .empty_o      (empty),
    .full_o       (full),
    .idle_o       (idle),
    .timeout_o    (timeout)
  );

  initial seq_if.clk = 1'b0;
  always #5 seq_if.clk = ~seq_if.clk;

  function automatic logic [31:0] ea(input logic [31:0] base, input int i);
    return base + 32'(4 * i);
  endfunction

  function automatic logic [31:0] ed(input logic [31:0] base, input int i);
    return ~(base + 32'(4 * i));
  endfunction

  task automatic tick();
    @(posedge seq_if.clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_addr  = ea(base, i);
      push_data  = ed(base, i);
      tick();
    end
    push_valid = 1'b0;
  endtask

  // status = {req, ready, empty, full, idle, timeout}
  task automatic test_reset();
    seq_if.rst = 1'b1;
    tick();
    tick();
    seq_if.rst = 1'b0;
    n_tests++;
    if ({wr_req, push_ready, empty, full, idle, timeout} !== 6'b011010) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected %b", {wr_req, push_ready, empty, full, idle, timeout}, 6'b011010);
    end
    n_tests++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
    n_tests++;
    if ({wr_addr, wr_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_wr_bus: got %h expected 0", {wr_addr, wr_data});
    end
  endtask

  task automatic test_single();
    push_valid = 1'b1;
    push_addr  = 32'h100;
    push_data  = 32'hDEAD;
    tick();
    push_valid = 1'b0;
    n_tests++;
    if ({wr_req, wr_addr, wr_data} !== {1'b1, 32'h100, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL single_issue: got req=%b addr=%h data=%h expected req=1 addr=100 data=dead", wr_req, wr_addr, wr_data);
    end
    n_tests++;
    if ({level, empty, idle} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_level: got level=%0d empty=%b idle=%b expected 1/0/0", level, empty, idle);
    end
    tick();
    tick();
    n_tests++;
    if ({wr_req, wr_addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL single_hold: got req=%b addr=%h expected req=1 addr=100", wr_req, wr_addr);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    n_tests++;
    if ({wr_req, idle, empty, level} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL single_done: got req=%b idle=%b empty=%b level=%0d expected 0/1/1/0", wr_req, idle, empty, level);
    end
  endtask

  task automatic test_burst();
    push_seq(32'h1000, 8);
    n_tests++;
    if ({full, push_ready, level} !== {1'b1, 1'b0, 4'd8}) begin
      n_fail++;
      $display("FAIL burst_full: got full=%b ready=%b level=%0d expected 1/0/8", full, push_ready, level);
    end
    n_tests++;
    if ({wr_req, wr_addr, wr_data} !== {1'b1, ea(32'h1000, 0), ed(32'h1000, 0)}) begin
      n_fail++;
      $display("FAIL burst_head0: got req=%b addr=%h data=%h expected addr=%h", wr_req, wr_addr, wr_data, ea(32'h1000, 0));
    end
    // Push while full is refused even with a same-cycle pop.
    push_valid = 1'b1;
    push_addr  = 32'hBAD0;
    push_data  = 32'hBAD1;
    wr_ack     = 1'b1;
    tick();
    push_valid = 1'b0;
    n_tests++;
    if (level !== 4'd7) begin
      n_fail++;
      $display("FAIL burst_full_push: got level=%0d expected 7", level);
    end
    for (int i = 1; i < 8; i++) begin
      n_tests++;
      if ({wr_req, wr_addr, wr_data} !== {1'b1, ea(32'h1000, i), ed(32'h1000, i)}) begin
        n_fail++;
        $display("FAIL burst_drain%0d: got req=%b addr=%h data=%h expected req=1 addr=%h data=%h",
                 i, wr_req, wr_addr, wr_data, ea(32'h1000, i), ed(32'h1000, i));
      end
      tick();
    end
    wr_ack = 1'b0;
    n_tests++;
    if ({wr_req, empty, level} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL burst_empty: got req=%b empty=%b level=%0d expected 0/1/0", wr_req, empty, level);
    end
  endtask

  task automatic test_push_ack();
    push_seq(32'h2000, 3);
    n_tests++;
    if ({level, wr_addr} !== {4'd3, ea(32'h2000, 0)}) begin
      n_fail++;
      $display("FAIL pa_setup: got level=%0d addr=%h expected 3 %h", level, wr_addr, ea(32'h2000, 0));
    end
    push_valid = 1'b1;
    push_addr  = ea(32'h2000, 3);
    push_data  = ed(32'h2000, 3);
    wr_ack     = 1'b1;
    tick();
    push_valid = 1'b0;
    n_tests++;
    if ({level, wr_req, wr_addr} !== {4'd3, 1'b1, ea(32'h2000, 1)}) begin
      n_fail++;
      $display("FAIL pa_same_cycle: got level=%0d req=%b addr=%h expected 3 1 %h", level, wr_req, wr_addr, ea(32'h2000, 1));
    end
    for (int i = 2; i < 4; i++) begin
      tick();
      n_tests++;
      if ({wr_req, wr_addr, wr_data} !== {1'b1, ea(32'h2000, i), ed(32'h2000, i)}) begin
        n_fail++;
        $display("FAIL pa_drain%0d: got req=%b addr=%h data=%h expected addr=%h", i, wr_req, wr_addr, wr_data, ea(32'h2000, i));
      end
    end
    tick();
    wr_ack = 1'b0;
    n_tests++;
    if ({wr_req, level} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL pa_empty: got req=%b level=%0d expected 0 0", wr_req, level);
    end
  endtask

  task automatic test_flush();
    push_seq(32'h3000, 5);
    n_tests++;
    if (level !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_setup: got level=%0d expected 5", level);
    end
    flush      = 1'b1;
    push_valid = 1'b1;
    push_addr  = 32'hF00;
    push_data  = 32'hF01;
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    n_tests++;
    if ({level, wr_req, wr_addr, wr_data} !== {4'd1, 1'b1, ea(32'h3000, 0), ed(32'h3000, 0)}) begin
      n_fail++;
      $display("FAIL flush_keep_head: got level=%0d req=%b addr=%h data=%h expected 1 1 %h", level, wr_req, wr_addr, wr_data, ea(32'h3000, 0));
    end
    tick();
    n_tests++;
    if ({level, wr_req, wr_addr} !== {4'd1, 1'b1, ea(32'h3000, 0)}) begin
      n_fail++;
      $display("FAIL flush_hold: got level=%0d req=%b addr=%h expected 1 1 %h", level, wr_req, wr_addr, ea(32'h3000, 0));
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    n_tests++;
    if ({wr_req, empty, idle} !== 3'b011) begin
      n_fail++;
      $display("FAIL flush_after_ack: got req=%b empty=%b idle=%b expected 0 1 1", wr_req, empty, idle);
    end
  endtask

  task automatic test_flush_idle();
    push_valid = 1'b1;
    push_addr  = 32'h4000;
    push_data  = 32'h4001;
    flush      = 1'b1;
    tick();
    push_valid = 1'b0;
    flush      = 1'b0;
    n_tests++;
    if ({wr_req, level, empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_idle_push: got req=%b level=%0d empty=%b expected 0 0 1", wr_req, level, empty);
    end
  endtask

  task automatic test_reset_mid();
    push_seq(32'h5000, 4);
    n_tests++;
    if ({level, wr_req} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got level=%0d req=%b expected 4 1", level, wr_req);
    end
    seq_if.rst = 1'b1;
    tick();
    seq_if.rst = 1'b0;
    n_tests++;
    if ({wr_req, push_ready, empty, full, idle, timeout, level} !== {6'b011010, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_status: got %b level=%0d expected 011010 level=0", {wr_req, push_ready, empty, full, idle, timeout}, level);
    end
    n_tests++;
    if ({wr_addr, wr_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mid_wr_bus: got %h expected 0", {wr_addr, wr_data});
    end
  endtask

  task automatic test_timeout();
    push_seq(32'h6000, 1);
    for (int i = 0; i < 15; i++) tick();
`ifdef AXI_WQ_TIMEOUT_EN
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b expected 0", timeout);
    end
    tick();
    n_tests++;
    if ({timeout, wr_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_set: got timeout=%b req=%b expected 1 1", timeout, wr_req);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    n_tests++;
    if ({timeout, wr_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_sticky: got timeout=%b req=%b expected 1 0", timeout, wr_req);
    end
    seq_if.rst = 1'b1;
    tick();
    seq_if.rst = 1'b0;
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_reset: got %b expected 0", timeout);
    end
`else
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if ({timeout, wr_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_disabled: got timeout=%b req=%b expected 0 1", timeout, wr_req);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    n_tests++;
    if ({timeout, wr_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_disabled_ack: got timeout=%b req=%b expected 0 0", timeout, wr_req);
    end
`endif
  endtask

  initial begin
    seq_if.rst = 1'b1;
    push_valid = 1'b0;
    push_addr  = '0;
    push_data  = '0;
    flush      = 1'b0;
    wr_ack     = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_push_ack();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
